// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, enable mask, arbitration and a claim/complete handshake.
// Optional macro IRQ_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the lowest index wins.
module irq_controller #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             enable_we,
  input  logic [N_SRC-1:0] enable_wdata,
  output logic [N_SRC-1:0] enable_q,
  output logic [N_SRC-1:0] pending_q,
  output logic             cpu_irq,
  input  logic             claim_req,
  output logic             claim_valid,
  output logic [ID_W-1:0]  claim_id,
  input  logic             complete,
  input  logic [ID_W-1:0]  complete_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ASSERT, CLAIMED} state_t;

  state_t           state;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] avail;
  logic [N_SRC-1:0] clr_mask;
  logic [ID_W-1:0]  winner;
  logic             claim_ok;

  assign rise     = irq_src & ~src_q;
  assign avail    = pending_q & enable_q;
  assign claim_ok = (state == ASSERT) && claim_req && (avail != '0);
  // A new edge in the claim cycle re-sets the bit being cleared.
  assign clr_mask = claim_ok ? (N_SRC'(1) << winner) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   cand;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 0; off < N_SRC; off++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(N_SRC)) cand = cand - (ID_W+1)'(N_SRC);
      if (!found && avail[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (claim_ok) begin
      rr_ptr <= (winner == ID_W'(N_SRC-1)) ? '0 : winner + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (avail[i]) winner = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      src_q     <= irq_src;
      pending_q <= (pending_q & ~clr_mask) | rise;
      if (enable_we) enable_q <= enable_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cpu_irq     <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
      busy        <= 1'b0;
    end else begin
      claim_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (avail != '0) begin
            state   <= ASSERT;
            cpu_irq <= 1'b1;
          end
        end
        ASSERT: begin
          if (avail == '0) begin
            state   <= IDLE;
            cpu_irq <= 1'b0;
          end else if (claim_req) begin
            state       <= CLAIMED;
            claim_id    <= winner;
            claim_valid <= 1'b1;
            cpu_irq     <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CLAIMED: begin
          if (complete && (complete_id == claim_id)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; expectations adapt to IRQ_ROUND_ROBIN_EN.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] irq_src;
  logic       enable_we;
  logic [7:0] enable_wdata;
  logic [7:0] enable_q;
  logic [7:0] pending_q;
  logic       cpu_irq;
  logic       claim_req;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic       complete;
  logic [2:0] complete_id;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [2:0] A1 = 3'd5, A2 = 3'd2, B1 = 3'd5, B2 = 3'd2;
`else
  localparam logic [2:0] A1 = 3'd2, A2 = 3'd5, B1 = 3'd2, B2 = 3'd5;
`endif

  always #5 clk = ~clk;

  irq_controller #(.N_SRC(8), .ID_W(3)) dut (
    .clk(clk), .rstn(rstn), .irq_src(irq_src),
    .enable_we(enable_we), .enable_wdata(enable_wdata), .enable_q(enable_q),
    .pending_q(pending_q), .cpu_irq(cpu_irq),
    .claim_req(claim_req), .claim_valid(claim_valid), .claim_id(claim_id),
    .complete(complete), .complete_id(complete_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pend(input logic [7:0] m);
    irq_src = m;
    tick();
    irq_src = '0;
  endtask

  task automatic set_en(input logic [7:0] m);
    enable_we    = 1'b1;
    enable_wdata = m;
    tick();
    enable_we    = 1'b0;
  endtask

  task automatic claim_chk(input string tag, input logic [2:0] exp);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check({tag, "_vld"}, claim_valid, 1);
    check({tag, "_id"}, claim_id, exp);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_irq"}, cpu_irq, 0);
  endtask

  task automatic finish_id(input logic [2:0] id);
    complete    = 1'b1;
    complete_id = id;
    tick();
    complete    = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_p;
    rstn = 1'b0; irq_src = '0; enable_we = 1'b0; enable_wdata = '0;
    claim_req = 1'b0; complete = 1'b0; complete_id = '0;
    #12;
    check("rst_irq", cpu_irq, 0);
    check("rst_busy", busy, 0);
    check("rst_vld", claim_valid, 0);
    check("rst_id", claim_id, 0);
    check("rst_pend", pending_q, 0);
    check("rst_en", enable_q, 0);
    tick();
    rstn = 1'b1;
    tick();

    // basic claim of source 3
    set_en(8'hFF);
    check("t1_en", enable_q, 8'hFF);
    pend(8'h08);
    check("t1_pend", pending_q, 8'h08);
    check("t1_irq_k1", cpu_irq, 0);
    tick();
    check("t1_irq_k2", cpu_irq, 1);
    claim_chk("t1_c", 3'd3);
    check("t1_pend_clr", pending_q, 8'h00);
    tick();
    check("t1_pulse", claim_valid, 0);
    finish_id(3'd3);
    check("t1_done", busy, 0);

    // two pending sources, arbitration order
    pend(8'h24);
    check("t2_pend", pending_q, 8'h24);
    tick();
    check("t2_irq", cpu_irq, 1);
    claim_chk("t2_c1", A1);
    exp_p = 8'h24;
    exp_p[A1] = 1'b0;
    check("t2_pend_left", pending_q, exp_p);
    finish_id(A1);
    check("t2_busy0", busy, 0);
    check("t2_irq_gap", cpu_irq, 0);
    tick();
    check("t2_reassert", cpu_irq, 1);
    claim_chk("t2_c2", A2);
    finish_id(A2);
    check("t2_pend_empty", pending_q, 0);
    tick();
    check("t2_idle", cpu_irq, 0);
    pend(8'h24);
    tick();
    claim_chk("t2_c3", B1);
    finish_id(B1);
    tick();
    claim_chk("t2_c4", B2);
    finish_id(B2);

    // masking and enable writes
    set_en(8'h00);
    pend(8'h10);
    check("t3_pend", pending_q, 8'h10);
    tick(); tick();
    check("t3_masked", cpu_irq, 0);
    set_en(8'h10);
    check("t3_en_k1", cpu_irq, 0);
    tick();
    check("t3_en_k2", cpu_irq, 1);
    set_en(8'h00);
    check("t3_dis_k1", cpu_irq, 1);
    tick();
    check("t3_drop", cpu_irq, 0);
    set_en(8'h10);
    tick();
    check("t3_rearm", cpu_irq, 1);
    enable_we = 1'b1; enable_wdata = 8'h00; claim_req = 1'b1;
    tick();
    enable_we = 1'b0; claim_req = 1'b0;
    check("t3_oldmask_vld", claim_valid, 1);
    check("t3_oldmask_id", claim_id, 3'd4);
    check("t3_newmask", enable_q, 8'h00);
    set_en(8'hFF);
    finish_id(3'd4);
    check("t3_done", busy, 0);

    // completion id matching
    pend(8'h02);
    tick();
    claim_chk("t4_c", 3'd1);
    finish_id(3'd2);
    check("t4_wrong_id", busy, 1);
    finish_id(3'd1);
    check("t4_right_id", busy, 0);
    tick();
    check("t4_idle", cpu_irq, 0);

    // edges while claimed, set-wins, idle claim
    pend(8'h02);
    tick();
    claim_chk("t5_c", 3'd1);
    pend(8'h40);
    check("t5_pend", pending_q, 8'h40);
    tick(); tick();
    check("t5_hold", cpu_irq, 0);
    finish_id(3'd1);
    check("t5_cmpl_k0", cpu_irq, 0);
    tick();
    check("t5_reassert", cpu_irq, 1);
    irq_src = 8'h40; claim_req = 1'b1;
    tick();
    irq_src = 8'h00; claim_req = 1'b0;
    check("t5_sw_vld", claim_valid, 1);
    check("t5_sw_id", claim_id, 3'd6);
    check("t5_set_wins", pending_q, 8'h40);
    finish_id(3'd6);
    tick();
    check("t5_again", cpu_irq, 1);
    claim_chk("t5_c2", 3'd6);
    finish_id(3'd6);
    check("t5_empty", pending_q, 0);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check("t5_idle_vld", claim_valid, 0);
    check("t5_idle_id", claim_id, 3'd6);

    // asynchronous reset while busy
    pend(8'h04);
    tick();
    claim_chk("t6_c", 3'd2);
    pend(8'h80);
    check("t6_pend", pending_q, 8'h80);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_irq", cpu_irq, 0);
    check("t6_busy", busy, 0);
    check("t6_pend0", pending_q, 0);
    check("t6_en0", enable_q, 0);
    check("t6_id0", claim_id, 0);
    tick();
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
